test_run_sequencer: RTL and testbench
=====================================

Name: test_run_sequencer

Overview:
- Avalon-MM slave on avalon_clock that sequences back-to-back test runs of the dual-clock (pos/neg PLL) BRAM test control unit, sweeping it over consecutive address blocks.
- Drives the unit's go/set_addr/num; takes its done_pos/done_neg flags, which are asynchronous to avalon_clock, through synchronizers.
- Adds a per-run timeout, a PLL-lock precheck and a completion interrupt, so software starts one batch instead of polling every run.

Parameters:
- ID, 2, value returned at register 7
- SETUP_CYCLES, 4, avalon cycles that set_addr/num are held stable with go low before go rises (≥3 for PLL-domain capture)
- SYNC_STAGES, 2, flop stages on done_pos, done_neg and pll_lock

Ports:
- avalon_clock  in  1  clock; all logic in this domain
- resetn  in  1  synchronous, active-low reset
- address  in  3  register select
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- read  in  1  Avalon read strobe
- readdata  out  32  registered read data, 1-cycle latency
- pll_lock  in  1  async PLL lock
- tu_done_pos  in  1  async done flag, pos domain
- tu_done_neg  in  1  async done flag, neg domain
- tu_go  out  1  run request to test unit
- tu_set_addr  out  11  run start address
- tu_num  out  12  run end address (exclusive)
- irq  out  1  level interrupt

Behaviour:
- Registers:
  - 0 CTRL: W bit0 start, bit1 abort, bit2 irq_en (stored). R {state[2:0], irq_en}.
  - 1 BASE[10:0].
  - 2 LEN[11:0].
  - 3 BLOCKS[7:0].
  - 4 GAP[15:0].
  - 5 STATUS: R {runs_done[7:0] at [15:8], lock_err[3], timeout_err[2], done[1], busy[0]}. W1C bits 1–3.
  - 6 TIMEOUT[23:0]; 0 disables the timeout.
  - 7 ID, read-only.
- Register access rules:
  - Unmapped reads return 0.
  - Writes to regs 1–4 and 6 while busy are ignored.
  - If a W1C write and a hardware set of the same status bit occur in the same cycle, the set wins.
- Reset state: all registers 0, state IDLE, tu_go=0, tu_set_addr=0, tu_num=0, readdata=0, irq=0. Reset mid-run drops tu_go on the next edge; the sequencer does not wait for the unit to drain.
- FSM:
  - IDLE: busy=0, tu_go=0. On start with abort=0:
    - If LEN==0 or BLOCKS==0: set done, stay in IDLE.
    - Otherwise: clear runs_done, set cur_addr=BASE, go to CHECK.
  - CHECK: 1 cycle. If synced pll_lock=0: set lock_err, go to IDLE. Otherwise go to SETUP.
  - SETUP: tu_go=0, tu_set_addr=cur_addr, tu_num=min(cur_addr+LEN, 2048). Hold SETUP_CYCLES cycles, then go to RUN.
  - RUN: tu_go=1; timeout counter counts from 0.
    - When both synced done flags are 1: go to DRAIN.
    - If TIMEOUT≠0 and counter==TIMEOUT-1: set timeout_err, set the abort flag, go to DRAIN.
  - DRAIN: tu_go=0. Wait until both synced done flags are 0 (the unit clears done while go is low).
    - If the abort flag is set: go to IDLE; runs_done is not incremented.
    - Otherwise: runs_done+1, cur_addr=(cur_addr+LEN) mod 2048. If runs_done+1==BLOCKS go to FINISH, else go to GAP.
  - GAP: count GAP idle cycles (0 means 0 cycles), then go to CHECK.
  - FINISH: set done, go to IDLE.
- Abort write:
  - In CHECK, SETUP or GAP: go straight to IDLE.
  - In RUN: set the abort flag, go to DRAIN.
  - Start and abort in the same cycle: abort wins.
  - Start while busy: ignored.
- irq = irq_en & (done | timeout_err | lock_err), registered.
- The runs_done field saturates at 255.

Test Plan:
- BASE=0, LEN=16, BLOCKS=3, GAP=0, start; model the unit's done as 20 pll cycles after go → tu_set_addr/tu_num sequence 0/16, 16/32, 32/48; STATUS=0x0302; irq=1 when irq_en=1.
- BASE=2040, LEN=16, BLOCKS=2 → run 1 is 2040/2048 (clamped); run 2 is 8/24 (wrap); done set.
- TIMEOUT=100, done model never asserts → tu_go falls 100 cycles after rise; timeout_err=1, runs_done=0; FSM returns to IDLE only after the done flags are low.
- pll_lock=0 at start → lock_err=1, tu_go never asserted; W1C 0x8 to STATUS clears it and irq drops.
- Abort during run 2 of 4 → tu_go drops next cycle; runs_done=1; done=0; a start written while busy has no effect.
- LEN=0, start → done=1 within 1 cycle, tu_go stays 0; a write to BASE while busy leaves the readback unchanged.

Source files
------------

// File: rtl/test_run_sequencer.sv
// Avalon-MM batch sequencer for the dual-clock BRAM test control unit: sweeps
// consecutive address blocks with per-run timeout, PLL-lock precheck and irq.
module test_run_sequencer #(
  parameter int unsigned ID           = 2,
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        avalon_clock,
  input  logic        resetn,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        pll_lock,
  input  logic        tu_done_pos,
  input  logic        tu_done_neg,
  output logic        tu_go,
  output logic [10:0] tu_set_addr,
  output logic [11:0] tu_num,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SETUP  = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_GAP    = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  localparam logic [23:0] SETUP_LAST = 24'(SETUP_CYCLES - 1);

  state_t      state, state_next;
  logic [10:0] base_reg;
  logic [11:0] len_reg;
  logic [7:0]  blocks_reg;
  logic [15:0] gap_reg;
  logic [23:0] timeout_reg;
  logic        irq_en;
  logic        st_done, st_timeout, st_lock;
  logic [7:0]  runs_done;
  logic [10:0] cur_addr;
  logic        abort_flag;
  logic [23:0] cnt;

  logic [SYNC_STAGES-1:0] pos_sync, neg_sync, lock_sync;
  logic pos_s, neg_s, lock_s;

  logic        busy, wr_ctrl, start_req, abort_req, cfg_wr, w1c;
  logic        cnt_clr, set_done, set_lock, set_tmo, abort_set;
  logic        batch_start, run_done, load_out;
  logic [8:0]  runs_inc;
  logic [12:0] end_sum;
  logic [11:0] num_calc;
  logic [10:0] next_addr;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:24];

  // done/lock flags come from other clock domains
  always_ff @(posedge avalon_clock) begin
    if (!resetn) begin
      pos_sync  <= '0;
      neg_sync  <= '0;
      lock_sync <= '0;
    end else begin
      pos_sync  <= {pos_sync[SYNC_STAGES-2:0], tu_done_pos};
      neg_sync  <= {neg_sync[SYNC_STAGES-2:0], tu_done_neg};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign pos_s  = pos_sync[SYNC_STAGES-1];
  assign neg_s  = neg_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

  assign busy      = (state != S_IDLE);
  assign wr_ctrl   = write && (address == 3'd0);
  assign start_req = wr_ctrl && writedata[0] && !writedata[1];
  assign abort_req = wr_ctrl && writedata[1];
  assign cfg_wr    = write && !busy;
  assign w1c       = write && (address == 3'd5);

  assign runs_inc  = {1'b0, runs_done} + 9'd1;
  assign end_sum   = {2'b00, cur_addr} + {1'b0, len_reg};
  assign num_calc  = (end_sum > 13'd2048) ? 12'd2048 : end_sum[11:0];
  assign next_addr = cur_addr + len_reg[10:0];

  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    set_done    = 1'b0;
    set_lock    = 1'b0;
    set_tmo     = 1'b0;
    abort_set   = 1'b0;
    batch_start = 1'b0;
    run_done    = 1'b0;
    load_out    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_req) begin
          if (len_reg == '0 || blocks_reg == '0) begin
            set_done = 1'b1;
          end else begin
            batch_start = 1'b1;
            state_next  = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (abort_req) begin
          state_next = S_IDLE;
        end else if (!lock_s) begin
          set_lock   = 1'b1;
          state_next = S_IDLE;
        end else begin
          load_out   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort_req) begin
          state_next = S_IDLE;
        end else if (cnt == SETUP_LAST) begin
          cnt_clr    = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_req) begin
          abort_set  = 1'b1;
          state_next = S_DRAIN;
        end else if (pos_s && neg_s) begin
          state_next = S_DRAIN;
        end else if (timeout_reg != '0 && cnt == timeout_reg - 24'd1) begin
          set_tmo    = 1'b1;
          abort_set  = 1'b1;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_req) abort_set = 1'b1;
        if (!pos_s && !neg_s) begin
          if (abort_flag || abort_req) begin
            state_next = S_IDLE;
          end else begin
            run_done = 1'b1;
            if (runs_inc == {1'b0, blocks_reg}) begin
              state_next = S_FINISH;
            end else if (gap_reg == '0) begin
              state_next = S_CHECK;
            end else begin
              cnt_clr    = 1'b1;
              state_next = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (abort_req) begin
          state_next = S_IDLE;
        end else if (cnt == {8'h00, gap_reg} - 24'd1) begin
          state_next = S_CHECK;
        end
      end
      S_FINISH: begin
        set_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge avalon_clock) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tu_go       <= 1'b0;
      tu_set_addr <= '0;
      tu_num      <= '0;
      abort_flag  <= 1'b0;
      runs_done   <= '0;
      cur_addr    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_clr ? '0 : cnt + 24'd1;
      // go tracks the next state so it drops on the same edge RUN is left
      tu_go <= (state_next == S_RUN);
      if (load_out) begin
        tu_set_addr <= cur_addr;
        tu_num      <= num_calc;
      end
      if (batch_start)    abort_flag <= 1'b0;
      else if (abort_set) abort_flag <= 1'b1;
      if (batch_start) begin
        runs_done <= '0;
        cur_addr  <= base_reg;
      end else if (run_done) begin
        if (runs_done != 8'hFF) runs_done <= runs_inc[7:0];
        cur_addr <= next_addr;
      end
    end
  end

  always_ff @(posedge avalon_clock) begin
    if (!resetn) begin
      base_reg    <= '0;
      len_reg     <= '0;
      blocks_reg  <= '0;
      gap_reg     <= '0;
      timeout_reg <= '0;
      irq_en      <= 1'b0;
      st_done     <= 1'b0;
      st_timeout  <= 1'b0;
      st_lock     <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= writedata[2];
      if (cfg_wr) begin
        unique case (address)
          3'd1:    base_reg    <= writedata[10:0];
          3'd2:    len_reg     <= writedata[11:0];
          3'd3:    blocks_reg  <= writedata[7:0];
          3'd4:    gap_reg     <= writedata[15:0];
          3'd6:    timeout_reg <= writedata[23:0];
          default: ;
        endcase
      end
      // hardware set takes priority over a coincident W1C
      if (set_done)                  st_done    <= 1'b1;
      else if (w1c && writedata[1])  st_done    <= 1'b0;
      if (set_tmo)                   st_timeout <= 1'b1;
      else if (w1c && writedata[2])  st_timeout <= 1'b0;
      if (set_lock)                  st_lock    <= 1'b1;
      else if (w1c && writedata[3])  st_lock    <= 1'b0;
      irq <= irq_en & (st_done | st_timeout | st_lock);
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      3'd0: rd_mux = {28'h0, state, irq_en};
      3'd1: rd_mux = {21'h0, base_reg};
      3'd2: rd_mux = {20'h0, len_reg};
      3'd3: rd_mux = {24'h0, blocks_reg};
      3'd4: rd_mux = {16'h0, gap_reg};
      3'd5: rd_mux = {16'h0, runs_done, 4'h0, st_lock, st_timeout, st_done, busy};
      3'd6: rd_mux = {8'h0, timeout_reg};
      3'd7: rd_mux = 32'(ID);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge avalon_clock) begin
    if (!resetn)   readdata <= '0;
    else if (read) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_test_run_sequencer.sv
// Scoreboard bench for test_run_sequencer: register reads and run launches are
// queued as expectations and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_test_run_sequencer;

  logic        avalon_clock = 1'b0;
  logic        pll_clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        pll_lock = 1'b1;
  logic        tu_done_pos, tu_done_neg;
  logic        model_pos = 1'b0, model_neg = 1'b0, force_pos = 1'b0;
  logic        tu_go;
  logic [10:0] tu_set_addr;
  logic [11:0] tu_num;
  logic        irq;

  int tests = 0;
  int fails = 0;
  bit model_en = 1'b1;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [22:0] run_q[$];
  rd_exp_t     mon_e;
  logic [22:0] mon_r;
  logic        rd_seen = 1'b0;
  logic        go_prev = 1'b0;

  assign tu_done_pos = model_pos | force_pos;
  assign tu_done_neg = model_neg;

  always #5 avalon_clock = ~avalon_clock;
  always #3 pll_clk = ~pll_clk;

  test_run_sequencer #(.ID(2), .SETUP_CYCLES(4), .SYNC_STAGES(2)) dut (
    .avalon_clock(avalon_clock),
    .resetn(resetn),
    .address(address),
    .write(write),
    .writedata(writedata),
    .read(read),
    .readdata(readdata),
    .pll_lock(pll_lock),
    .tu_done_pos(tu_done_pos),
    .tu_done_neg(tu_done_neg),
    .tu_go(tu_go),
    .tu_set_addr(tu_set_addr),
    .tu_num(tu_num),
    .irq(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: read data one cycle after a read strobe, run parameters on go rise
  always @(negedge avalon_clock) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got 0x%0h required no read", readdata);
      end else begin
        mon_e = rd_q.pop_front();
        chk(mon_e.name, readdata, mon_e.exp);
      end
    end
    rd_seen = read;
    if (tu_go === 1'b1 && go_prev !== 1'b1) begin
      if (run_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL run_unexpected: got addr %0d num %0d required no run", tu_set_addr, tu_num);
      end else begin
        mon_r = run_q.pop_front();
        chk("run_addr_num", {9'h0, tu_set_addr, tu_num}, {9'h0, mon_r});
      end
    end
    go_prev = tu_go;
  end

  // Test unit model: done ~20 pll cycles after go, cleared a few cycles after go falls
  initial begin
    int n;
    forever begin
      wait (tu_go === 1'b1);
      n = 0;
      while (tu_go === 1'b1 && n < 20) begin
        @(posedge pll_clk);
        n++;
      end
      if (model_en && tu_go === 1'b1) begin
        model_pos = 1'b1;
        @(negedge pll_clk);
        model_neg = 1'b1;
      end
      wait (tu_go === 1'b0);
      if (model_en) begin
        repeat (3) @(posedge pll_clk);
        model_pos = 1'b0;
        @(negedge pll_clk);
        model_neg = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got no finish required finish before 1ms");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge avalon_clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge avalon_clock);
    #1;
    address = a;
    writedata = d;
    write = 1'b1;
    @(posedge avalon_clock);
    #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    rd_exp_t e;
    e.name = nm;
    e.exp = exp;
    rd_q.push_back(e);
    @(posedge avalon_clock);
    #1;
    address = a;
    read = 1'b1;
    @(posedge avalon_clock);
    #1;
    read = 1'b0;
  endtask

  task automatic wait_go(input logic lvl, input int maxc, output int n);
    n = 0;
    while (tu_go !== lvl && n < maxc) begin
      @(posedge avalon_clock);
      #1;
      n++;
    end
  endtask

  initial begin
    int n1, n2;
    cyc(3);
    chk("rst_tu_go", {31'h0, tu_go}, 32'h0);
    chk("rst_set_addr", {21'h0, tu_set_addr}, 32'h0);
    chk("rst_num", {20'h0, tu_num}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    resetn = 1'b1;
    cyc(3);
    for (int unsigned i = 0; i < 7; i++) rd(3'(i), 32'h0, "rst_reg");
    rd(3'd7, 32'h2, "rst_id");

    // Three back-to-back 16-word blocks from 0 with irq enabled
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd16);
    wr(3'd3, 32'd3);
    wr(3'd4, 32'd0);
    run_q.push_back({11'd0, 12'd16});
    run_q.push_back({11'd16, 12'd32});
    run_q.push_back({11'd32, 12'd48});
    wr(3'd0, 32'h5);
    cyc(200);
    rd(3'd5, 32'h0302, "t1_status");
    chk("t1_irq", {31'h0, irq}, 32'h1);
    rd(3'd0, 32'h1, "t1_ctrl");
    wr(3'd5, 32'hE);
    cyc(2);
    chk("t1_irq_cleared", {31'h0, irq}, 32'h0);

    // Clamp at 2048 then wrap to 8
    wr(3'd1, 32'd2040);
    wr(3'd3, 32'd2);
    run_q.push_back({11'd2040, 12'd2048});
    run_q.push_back({11'd8, 12'd24});
    wr(3'd0, 32'h1);
    cyc(200);
    rd(3'd5, 32'h0202, "t2_status");
    chk("t2_irq_disabled", {31'h0, irq}, 32'h0);
    wr(3'd5, 32'hE);

    // Timeout with one done flag stuck high through the drain
    model_en = 1'b0;
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd1);
    wr(3'd6, 32'd100);
    run_q.push_back({11'd0, 12'd16});
    wr(3'd0, 32'h1);
    wait_go(1'b1, 60, n1);
    chk("t3_go_rise", {31'h0, tu_go}, 32'h1);
    wait_go(1'b0, 90, n1);
    force_pos = 1'b1;
    wait_go(1'b0, 50, n2);
    chk("t3_go_width", 32'(n1 + n2), 32'd100);
    cyc(10);
    rd(3'd0, 32'h8, "t3_ctrl_drain");
    force_pos = 1'b0;
    cyc(10);
    rd(3'd5, 32'h0004, "t3_status");
    rd(3'd0, 32'h0, "t3_ctrl_idle");
    wr(3'd6, 32'd0);
    wr(3'd5, 32'hE);
    model_en = 1'b1;

    // PLL unlocked at start
    pll_lock = 1'b0;
    cyc(5);
    wr(3'd0, 32'h5);
    cyc(10);
    rd(3'd5, 32'h0008, "t4_lock_err");
    chk("t4_irq", {31'h0, irq}, 32'h1);
    wr(3'd5, 32'h8);
    cyc(3);
    chk("t4_irq_cleared", {31'h0, irq}, 32'h0);
    rd(3'd5, 32'h0, "t4_status_clear");
    pll_lock = 1'b1;
    cyc(5);

    // Abort during run 2 of 4, with a start written while busy
    wr(3'd3, 32'd4);
    wr(3'd4, 32'd5);
    run_q.push_back({11'd0, 12'd16});
    run_q.push_back({11'd16, 12'd32});
    wr(3'd0, 32'h1);
    wait_go(1'b1, 100, n1);
    wait_go(1'b0, 100, n1);
    wait_go(1'b1, 100, n1);
    chk("t5_run2_go", {31'h0, tu_go}, 32'h1);
    cyc(3);
    wr(3'd0, 32'h1);
    wr(3'd0, 32'h2);
    chk("t5_go_drop", {31'h0, tu_go}, 32'h0);
    cyc(10);
    rd(3'd5, 32'h0100, "t5_status");

    // LEN=0 finishes immediately; BASE write while busy is dropped
    wr(3'd2, 32'd0);
    wr(3'd0, 32'h1);
    chk("t6_no_go", {31'h0, tu_go}, 32'h0);
    rd(3'd5, 32'h0102, "t6_len0_done");
    wr(3'd5, 32'h2);
    wr(3'd1, 32'd16);
    wr(3'd2, 32'd16);
    wr(3'd3, 32'd1);
    run_q.push_back({11'd16, 12'd32});
    wr(3'd0, 32'h1);
    wr(3'd1, 32'h55);
    rd(3'd1, 32'd16, "t6_base_busy");
    cyc(100);
    rd(3'd5, 32'h0102, "t6_status");
    rd(3'd2, 32'd16, "t6_len");
    rd(3'd7, 32'h2, "t6_id");

    cyc(5);
    chk("rd_q_empty", 32'(rd_q.size()), 32'h0);
    chk("run_q_empty", 32'(run_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
